decode_issue_queue: RTL
=======================

DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 Parameter XLEN, default 32: datapath width of operands and immediates.
REQ-002 Parameter DEPTH, default 2: queue entries; power of two, at least 2.
REQ-003 Parameter FUNC_W, default 10: ALU function code width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  decoded instruction present; in_ready  output  1  queue accepts it.
REQ-007 in_func  input  FUNC_W  function code; in_imm  input  XLEN  immediate; in_en_imm  input  1  operand 2 is the immediate.
REQ-008 in_a0, in_a1, in_a2  input  5 each  source 1, source 2, destination register numbers.
REQ-009 in_d0, in_d1  input  XLEN each  register-file read data for in_a0, in_a1.
REQ-010 in_ctrl  input  8  {en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_mem_wr, en_reg_wr, ld_code[2:0]}.
REQ-011 fwd_ex_en  input  1, fwd_ex_addr  input  5, fwd_ex_data  input  XLEN: execute-stage result bypass.
REQ-012 fwd_mem_en  input  1, fwd_mem_addr  input  5, fwd_mem_data  input  XLEN: memory-stage result bypass.
REQ-013 squash  input  1  flush all queued and incoming instructions.
REQ-014 out_valid  output  1  head entry valid; out_ready  input  1  downstream consumes head.
REQ-015 out_func  output  FUNC_W, out_imm  output  XLEN, out_ctrl  output  8, out_a2  output  5: head entry fields.
REQ-016 out_alu_data1, out_alu_data2, out_data_to_mem  output  XLEN each: head entry operands.
REQ-017 a2_hazard  output  5  destination register of the incoming instruction, for hazard detection.
REQ-018 count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-019 Push occurs when in_valid and in_ready are both 1; pop occurs when out_valid and out_ready are both 1.
REQ-020 in_ready shall be 1 exactly when count < DEPTH and squash is 0; a full queue with a simultaneous pop still holds in_ready at 0.
REQ-021 out_valid shall be 1 exactly when count != 0 and squash is 0.
REQ-022 Entries leave in push order; minimum latency from push edge to out_valid is 1 cycle (no combinational in-to-out path).
REQ-023 Operand resolution at push: src value = fwd_ex_data if fwd_ex_en and fwd_ex_addr == src and src != 0; else fwd_mem_data on the equivalent mem match; else in_d0/in_d1.
REQ-024 Register 0 is never forwarded; operands for x0 take in_d0/in_d1 unchanged.
REQ-025 Stored alu_data1 = resolved source 1; stored data_to_mem = resolved source 2; stored alu_data2 = in_imm if in_en_imm, else resolved source 2.
REQ-026 Each cycle, every occupied entry whose a0/a1 matches an enabled forward source (same priority and x0 rule) overwrites the corresponding stored operands; alu_data2 is updated only when its en_imm is 0.
REQ-027 An entry being pushed and an entry resident in the same cycle both see the same cycle's forward values.
REQ-028 When out_valid is 0, out_func, out_imm, out_ctrl, out_a2 and all out_* data shall read 0.
REQ-029 a2_hazard = in_a2 when in_valid is 1 and squash is 0, else 0 (combinational).
REQ-030 Squash cycle: no push, no pop; on the next edge count becomes 0, read and write pointers go to 0 and every entry becomes invalid.
REQ-031 count updates +1 on push only, -1 on pop only, unchanged on push and pop together; read and write pointers wrap modulo DEPTH.

Reset
REQ-032 While rst is 0: count = 0, pointers = 0, all entries invalid, out_valid = 0, in_ready = 0, all out_* = 0.
REQ-033 Assertion of rst takes effect immediately and asynchronously, including mid-push or mid-pop; the first push is accepted on the first rising edge after rst returns to 1.

Verification
REQ-034 Reset, then push 3 instructions with DEPTH=2 and out_ready=0 -> first two accepted, in_ready=0 on third, count=2.
REQ-035 Push with in_a0=5, fwd_ex_en=1, fwd_ex_addr=5, fwd_ex_data=0xAA, fwd_mem matching with 0xBB -> out_alu_data1=0xAA; with in_a0=0 -> in_d0 is used.
REQ-036 Entry with a1=7, en_imm=0 held with out_ready=0 for 3 cycles; fwd_mem_addr=7, data=0x1234 in cycle 2 -> out_alu_data2 and out_data_to_mem both read 0x1234; with en_imm=1 -> out_alu_data2 remains imm.
REQ-037 Full queue, squash=1 with in_valid=1 and out_ready=1 -> no handshake that cycle, count=0 and out_valid=0 next cycle, a2_hazard=0 during squash.
REQ-038 Continuous push and pop with out_ready=1 for 10 instructions -> throughput of 1 per cycle after the first, order preserved across pointer wrap, count steady at 1.
REQ-039 rst pulled low with count=2 between edges -> outputs zero immediately; after release count=0, in_ready=1.

Source files
------------

// File: rtl/decode_issue_queue.sv
// Decode-to-issue queue: holds decoded instructions with resolved operands and
// keeps resident operands current through the execute/memory result bypasses.
module decode_issue_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter int FUNC_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FUNC_W-1:0]          in_func,
  input  logic [XLEN-1:0]            in_imm,
  input  logic                       in_en_imm,
  input  logic [4:0]                 in_a0,
  input  logic [4:0]                 in_a1,
  input  logic [4:0]                 in_a2,
  input  logic [XLEN-1:0]            in_d0,
  input  logic [XLEN-1:0]            in_d1,
  input  logic [7:0]                 in_ctrl,
  input  logic                       fwd_ex_en,
  input  logic [4:0]                 fwd_ex_addr,
  input  logic [XLEN-1:0]            fwd_ex_data,
  input  logic                       fwd_mem_en,
  input  logic [4:0]                 fwd_mem_addr,
  input  logic [XLEN-1:0]            fwd_mem_data,
  input  logic                       squash,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FUNC_W-1:0]          out_func,
  output logic [XLEN-1:0]            out_imm,
  output logic [7:0]                 out_ctrl,
  output logic [4:0]                 out_a2,
  output logic [XLEN-1:0]            out_alu_data1,
  output logic [XLEN-1:0]            out_alu_data2,
  output logic [XLEN-1:0]            out_data_to_mem,
  output logic [4:0]                 a2_hazard,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              r_valid [DEPTH];
  logic [FUNC_W-1:0] r_func  [DEPTH];
  logic [XLEN-1:0]   r_imm   [DEPTH];
  logic              r_en_imm[DEPTH];
  logic [7:0]        r_ctrl  [DEPTH];
  logic [4:0]        r_a0    [DEPTH];
  logic [4:0]        r_a1    [DEPTH];
  logic [4:0]        r_a2    [DEPTH];
  logic [XLEN-1:0]   r_alu1  [DEPTH];
  logic [XLEN-1:0]   r_alu2  [DEPTH];
  logic [XLEN-1:0]   r_mem   [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic [XLEN:0]     w_src1;
  logic [XLEN:0]     w_src2;
  logic [XLEN:0]     w_upd1 [DEPTH];
  logic [XLEN:0]     w_upd2 [DEPTH];

  // Returns {hit, value}: execute bypass beats memory bypass, x0 never bypassed.
  function automatic logic [XLEN:0] f_resolve(
    input logic [4:0]      src,
    input logic [XLEN-1:0] dflt,
    input logic            ex_en,
    input logic [4:0]      ex_a,
    input logic [XLEN-1:0] ex_d,
    input logic            mem_en,
    input logic [4:0]      mem_a,
    input logic [XLEN-1:0] mem_d
  );
    if (src != 5'd0 && ex_en && ex_a == src)
      return {1'b1, ex_d};
    else if (src != 5'd0 && mem_en && mem_a == src)
      return {1'b1, mem_d};
    else
      return {1'b0, dflt};
  endfunction

  // Handshake and operand resolution for the incoming and resident entries.
  always_comb begin
    in_ready    = rst && !squash && (r_count < FULL);
    w_out_valid = (r_count != '0) && !squash;
    w_push      = in_valid && in_ready;
    w_pop       = w_out_valid && out_ready;
    a2_hazard   = (in_valid && !squash) ? in_a2 : 5'd0;
    w_src1 = f_resolve(in_a0, in_d0, fwd_ex_en, fwd_ex_addr, fwd_ex_data,
                       fwd_mem_en, fwd_mem_addr, fwd_mem_data);
    w_src2 = f_resolve(in_a1, in_d1, fwd_ex_en, fwd_ex_addr, fwd_ex_data,
                       fwd_mem_en, fwd_mem_addr, fwd_mem_data);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_upd1[i] = f_resolve(r_a0[i], r_alu1[i], fwd_ex_en, fwd_ex_addr, fwd_ex_data,
                            fwd_mem_en, fwd_mem_addr, fwd_mem_data);
      w_upd2[i] = f_resolve(r_a1[i], r_mem[i], fwd_ex_en, fwd_ex_addr, fwd_ex_data,
                            fwd_mem_en, fwd_mem_addr, fwd_mem_data);
    end
  end

  // Occupancy, pointers and entry valid bits; squash empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
    end else if (squash) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload: bypass refresh of resident operands, then the push write.
  // The push slot is never occupied, so the two never collide.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        if (w_upd1[i][XLEN]) r_alu1[i] <= w_upd1[i][XLEN-1:0];
        if (w_upd2[i][XLEN]) begin
          r_mem[i] <= w_upd2[i][XLEN-1:0];
          if (!r_en_imm[i]) r_alu2[i] <= w_upd2[i][XLEN-1:0];
        end
      end
    end
    if (w_push) begin
      r_func[r_wptr]   <= in_func;
      r_imm[r_wptr]    <= in_imm;
      r_en_imm[r_wptr] <= in_en_imm;
      r_ctrl[r_wptr]   <= in_ctrl;
      r_a0[r_wptr]     <= in_a0;
      r_a1[r_wptr]     <= in_a1;
      r_a2[r_wptr]     <= in_a2;
      r_alu1[r_wptr]   <= w_src1[XLEN-1:0];
      r_mem[r_wptr]    <= w_src2[XLEN-1:0];
      r_alu2[r_wptr]   <= in_en_imm ? in_imm : w_src2[XLEN-1:0];
    end
  end

  // Head entry presentation, forced to zero whenever nothing is offered.
  always_comb begin
    out_valid       = w_out_valid;
    count           = r_count;
    out_func        = '0;
    out_imm         = '0;
    out_ctrl        = '0;
    out_a2          = '0;
    out_alu_data1   = '0;
    out_alu_data2   = '0;
    out_data_to_mem = '0;
    if (w_out_valid) begin
      out_func        = r_func[r_rptr];
      out_imm         = r_imm[r_rptr];
      out_ctrl        = r_ctrl[r_rptr];
      out_a2          = r_a2[r_rptr];
      out_alu_data1   = r_alu1[r_rptr];
      out_alu_data2   = r_alu2[r_rptr];
      out_data_to_mem = r_mem[r_rptr];
    end
  end

endmodule
